// File: rtl/out_layer_seq.sv
// Sequential output neuron: time-shared fixed-point MAC over N_IN hidden values,
// hard-sigmoid activation and an optional delta-rule update of the internal weights.
module out_layer_seq #(
  parameter int N_IN     = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int LR_SHIFT = 2
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iSTART,
  output logic                     oREADY,
  input  logic                     iTRAIN,
  input  logic [N_IN*W-1:0]        iMID_VALUE,
  input  logic [W-1:0]             iTEACH,
  input  logic                     iWLOAD,
  input  logic [$clog2(N_IN)-1:0]  iWADDR,
  input  logic [W-1:0]             iWDATA,
  output logic [N_IN*W-1:0]        oWEIGHT,
  output logic [W-1:0]             oOUTPUT,
  output logic                     oVALID,
  output logic                     oDONE
);

  localparam int AW   = $clog2(N_IN);
  localparam int ACCW = W + AW + 1;
  localparam int WIDE = 2*W + 8;
  localparam logic [AW-1:0] LAST = AW'(N_IN - 1);
  localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [WIDE-1:0] ONE     = WIDE'(1) <<< FRAC;
  localparam logic signed [WIDE-1:0] HALF    = ONE >>> 1;

  typedef enum logic [2:0] {IDLE, MAC, ACT, DELTA, UPD} stateT;

  function automatic logic [W-1:0] satW(input logic signed [WIDE-1:0] v);
    logic [W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[W-1:0];
    else                  r = v[W-1:0];
    return r;
  endfunction

  stateT state, stateNext;
  logic  validNext, doneNext;

  logic [N_IN-1:0][W-1:0] weightReg;
  logic [N_IN-1:0][W-1:0] xCap;
  logic [W-1:0]           teachCap;
  logic                   trainCap;
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          idx;
  logic signed [W-1:0]    delta;
  logic                   loadOk;

  // One multiplier serves both phases: x*w while accumulating, delta*x while updating.
  logic signed [W-1:0]    mulA, mulB, macTerm, wCur, wUpd;
  logic signed [2*W-1:0]  mulProd, mulShift;

  assign mulA     = $signed(xCap[idx]);
  assign wCur     = $signed(weightReg[idx]);
  assign mulB     = (state == UPD) ? delta : wCur;
  assign mulProd  = (2*W)'(mulA) * (2*W)'(mulB);
  assign mulShift = mulProd >>> FRAC;
  // Each term is clamped to W so the narrow accumulator can never wrap.
  assign macTerm  = $signed(satW(WIDE'(mulShift)));
  assign wUpd     = $signed(satW(WIDE'(wCur) + WIDE'(mulShift >>> LR_SHIFT)));

  logic signed [ACCW-1:0] accScaled;
  logic signed [WIDE-1:0] zRaw, zWide, errW, slopeW, errSlope;
  logic [W-1:0]           zClamp;

  assign accScaled = acc >>> 2;
  assign zRaw      = WIDE'(accScaled) + HALF;
  assign zWide     = WIDE'($signed(oOUTPUT));
  assign errW      = WIDE'($signed(teachCap)) - zWide;
  assign slopeW    = (zWide * (ONE - zWide)) >>> FRAC;
  assign errSlope  = (errW * slopeW) >>> FRAC;

  always_comb begin
    zClamp = zRaw[W-1:0];
    if (zRaw[WIDE-1])   zClamp = '0;
    else if (zRaw > ONE) zClamp = ONE[W-1:0];
  end

  assign oREADY = (state == IDLE);
  assign loadOk = (state == IDLE) && iWLOAD && (int'({1'b0, iWADDR}) < N_IN);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    validNext = 1'b0;
    doneNext  = 1'b0;
    case (state)
      IDLE:  if (iSTART) stateNext = MAC;
      MAC:   if (idx == LAST) stateNext = ACT;
      ACT: begin
        validNext = 1'b1;
        if (!trainCap) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = DELTA;
        end
      end
      DELTA: stateNext = UPD;
      UPD: begin
        if (idx == LAST) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc      <= '0;
      idx      <= '0;
      delta    <= '0;
      xCap     <= '0;
      teachCap <= '0;
      trainCap <= 1'b0;
      oOUTPUT  <= '0;
      oVALID   <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oVALID <= validNext;
      oDONE  <= doneNext;
      case (state)
        IDLE: begin
          if (iSTART) begin
            xCap     <= iMID_VALUE;
            teachCap <= iTEACH;
            trainCap <= iTRAIN;
            acc      <= '0;
            idx      <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(macTerm);
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        ACT:   oOUTPUT <= zClamp;
        DELTA: begin
          delta <= $signed(satW(errSlope));
          idx   <= '0;
        end
        UPD:   idx <= (idx == LAST) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  // A host load coinciding with iSTART lands before the first MAC reads the weight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)            weightReg         <= '0;
    else if (loadOk)        weightReg[iWADDR] <= iWDATA;
    else if (state == UPD)  weightReg[idx]    <= wUpd;
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : gWeightOut
    assign oWEIGHT[gi*W +: W] = weightReg[gi];
  end

endmodule

// File: tb/tb_out_layer_seq.sv
// Bench for out_layer_seq: directed scenarios with literal expectations plus a
// per-cycle compare against a result-level model of the neuron.
module tb_out_layer_seq;
  localparam int N_IN = 4;
  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int LR   = 0;
  localparam int AW   = $clog2(N_IN);

  logic              iCLK, iRST_N, iSTART, oREADY, iTRAIN, iWLOAD, oVALID, oDONE;
  logic [N_IN*W-1:0] iMID_VALUE, oWEIGHT;
  logic [W-1:0]      iTEACH, iWDATA, oOUTPUT;
  logic [AW-1:0]     iWADDR;

  out_layer_seq #(.N_IN(N_IN), .W(W), .FRAC(FRAC), .LR_SHIFT(LR)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .oREADY(oREADY), .iTRAIN(iTRAIN),
    .iMID_VALUE(iMID_VALUE), .iTEACH(iTEACH), .iWLOAD(iWLOAD), .iWADDR(iWADDR),
    .iWDATA(iWDATA), .oWEIGHT(oWEIGHT), .oOUTPUT(oOUTPUT), .oVALID(oVALID), .oDONE(oDONE)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Whole-operation result straight from the arithmetic rules.
  task automatic computeRun(input longint w[N_IN], input longint x[N_IN], input longint t,
                            input bit train, output longint z, output longint nw[N_IN]);
    longint acc, err, d, dl;
    acc = 0;
    for (int i = 0; i < N_IN; i++) acc += sat((w[i] * x[i]) >>> FRAC);
    z = (acc >>> 2) + (1 << (FRAC - 1));
    if (z < 0) z = 0;
    if (z > (1 << FRAC)) z = 1 << FRAC;
    nw = w;
    if (train) begin
      err = t - z;
      d   = (z * ((1 << FRAC) - z)) >>> FRAC;
      dl  = sat((err * d) >>> FRAC);
      for (int i = 0; i < N_IN; i++) nw[i] = sat(w[i] + (((dl * x[i]) >>> FRAC) >>> LR));
    end
  endtask

  // Model state: current weights/output plus progress through an accepted operation.
  longint wM[N_IN], mX[N_IN], nW[N_IN];
  longint curOut, nOut;
  bit     mBusy, mTrain, eValid, eDone;
  int     k;

  initial begin : modelProc
    forever begin
      @(posedge iCLK or negedge iRST_N);
      if (!iRST_N) begin
        for (int i = 0; i < N_IN; i++) wM[i] = 0;
        curOut = 0; mBusy = 0; eValid = 0; eDone = 0; k = 0;
      end else if (!mBusy) begin
        eValid = 0; eDone = 0;
        if (iWLOAD && int'(iWADDR) < N_IN) wM[iWADDR] = longint'($signed(iWDATA));
        if (iSTART) begin
          for (int i = 0; i < N_IN; i++) mX[i] = longint'($signed(iMID_VALUE[i*W +: W]));
          computeRun(wM, mX, longint'($signed(iTEACH)), iTRAIN, nOut, nW);
          mTrain = iTRAIN; mBusy = 1; k = 0;
        end
      end else begin
        k++;
        eValid = (k == N_IN + 1);
        if (eValid) curOut = nOut;
        if (mTrain && k >= N_IN + 3) wM[k-N_IN-3] = nW[k-N_IN-3];
        eDone = (k == (mTrain ? 2*N_IN + 2 : N_IN + 1));
        if (eDone) mBusy = 0;
      end
    end
  end

  initial begin : compareProc
    forever begin
      @(negedge iCLK);
      if (checkEn) begin
        check("mon.ready", oREADY, !mBusy);
        check("mon.valid", oVALID, eValid);
        check("mon.done",  oDONE,  eDone);
        check("mon.output", longint'($signed(oOUTPUT)), curOut);
        for (int i = 0; i < N_IN; i++)
          check($sformatf("mon.weight%0d", i), longint'($signed(oWEIGHT[i*W +: W])), wM[i]);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic loadW(input int a, input longint d);
    iWLOAD = 1'b1; iWADDR = AW'(a); iWDATA = W'(d);
    @(posedge iCLK); #1;
    iWLOAD = 1'b0;
  endtask

  task automatic setX(input longint x0, input longint x1, input longint x2, input longint x3);
    iMID_VALUE = {W'(x3), W'(x2), W'(x1), W'(x0)};
  endtask

  task automatic checkW(input string name, input longint w0, input longint w1,
                        input longint w2, input longint w3);
    longint e[N_IN];
    e = '{w0, w1, w2, w3};
    for (int i = 0; i < N_IN; i++)
      check($sformatf("%s.w%0d", name, i), longint'($signed(oWEIGHT[i*W +: W])), e[i]);
  endtask

  // Start an operation; cycle numbers count the start-sampling cycle as cycle 1.
  task automatic runOp(input bit train, input longint teach, input bit disturb,
                       output int validCyc, output int doneCyc, output int validCnt);
    logic [N_IN*W-1:0] savedX;
    iTRAIN = train; iTEACH = W'(teach); iSTART = 1'b1;
    @(posedge iCLK); #1;
    iSTART = 1'b0; iWLOAD = 1'b0;
    validCyc = 0; doneCyc = 0; validCnt = 0; savedX = iMID_VALUE;
    for (int c = 1; c <= 60; c++) begin
      if (disturb && c == 2) begin
        iSTART = 1'b1; iWLOAD = 1'b1; iWADDR = '0; iWDATA = W'(999); iMID_VALUE = '1;
      end
      if (disturb && c == 3) begin
        iSTART = 1'b0; iWLOAD = 1'b0; iMID_VALUE = savedX;
      end
      @(posedge iCLK); #1;
      if (oVALID) begin validCnt++; validCyc = c + 1; end
      if (oDONE) begin doneCyc = c + 1; break; end
    end
    $display("op train=%0b teach=%0d -> out=%0d valid@%0d done@%0d", train, teach,
             $signed(oOUTPUT), validCyc, doneCyc);
  endtask

  int vc, dc, vn, extra;

  initial begin : stim
    iRST_N = 1'b0; iSTART = 1'b0; iTRAIN = 1'b0; iWLOAD = 1'b0;
    iWADDR = '0; iWDATA = '0; iTEACH = '0; iMID_VALUE = '0;
    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    checkEn = 1'b1;
    check("reset.ready", oREADY, 1);
    check("reset.output", oOUTPUT, 0);
    checkW("reset", 0, 0, 0, 0);

    // All-zero inputs: activation sits at 0.5
    runOp(0, 0, 0, vc, dc, vn);
    check("zero.validCyc", vc, 6); check("zero.doneCyc", dc, 6);
    check("zero.output", oOUTPUT, 128);
    checkW("zero", 0, 0, 0, 0);

    // Inference: sum 256 -> 192
    loadW(0, 256); loadW(1, 256); setX(128, 128, 0, 0);
    runOp(0, 0, 0, vc, dc, vn);
    check("inf.output", oOUTPUT, 192); check("inf.validCnt", vn, 1);
    check("inf.validCyc", vc, 6); check("inf.doneCyc", dc, 6);

    // Training: delta 12, w0/w1 -> 262
    runOp(1, 256, 0, vc, dc, vn);
    check("train.output", oOUTPUT, 192); check("train.validCyc", vc, 6);
    check("train.doneCyc", dc, 11);
    checkW("train", 262, 262, 0, 0);

    // Busy: start/load/input changes mid-MAC are ignored
    loadW(0, 256); loadW(1, 256);
    runOp(0, 0, 1, vc, dc, vn);
    extra = 0;
    repeat (6) begin @(posedge iCLK); #1; if (oVALID) extra++; end
    check("busy.output", oOUTPUT, 192); check("busy.doneCyc", dc, 6);
    check("busy.validCnt", vn + extra, 1); check("busy.ready", oREADY, 1);
    checkW("busy", 256, 256, 0, 0);

    // Load in the same cycle as start is used by that computation
    iWLOAD = 1'b1; iWADDR = AW'(2); iWDATA = W'(256); setX(128, 128, 128, 0);
    runOp(0, 0, 0, vc, dc, vn);
    check("loadstart.output", oOUTPUT, 224);
    checkW("loadstart", 256, 256, 256, 0);

    // Positive saturation -> clamp at 1.0
    for (int i = 0; i < N_IN; i++) loadW(i, 32767);
    setX(32767, 32767, 32767, 32767);
    runOp(0, 0, 0, vc, dc, vn);
    check("sathi.output", oOUTPUT, 256);

    // Negative saturation -> clamp at 0
    loadW(0, -32768); loadW(1, 0); loadW(2, 0); loadW(3, 0);
    setX(32767, 0, 0, 0);
    runOp(0, 0, 0, vc, dc, vn);
    check("satlo.output", oOUTPUT, 0);

    // Training near full scale: update saturates instead of wrapping
    loadW(0, 1); loadW(1, 32000);
    setX(32767, 1, 0, 0);
    runOp(1, 32767, 0, vc, dc, vn);
    check("nowrap.output", oOUTPUT, 191); check("nowrap.doneCyc", dc, 11);
    checkW("nowrap", 32767, 32023, 0, 0);

    // Reset during UPD aborts and clears everything
    loadW(0, 256); loadW(1, 256); setX(128, 128, 0, 0);
    iTRAIN = 1'b1; iTEACH = W'(256); iSTART = 1'b1;
    @(posedge iCLK); #1 iSTART = 1'b0;
    repeat (N_IN + 3) @(posedge iCLK);
    #1 check("midupd.w0", longint'($signed(oWEIGHT[0 +: W])), 262);
    #2 iRST_N = 1'b0;
    #1;
    check("rst.output", oOUTPUT, 0); check("rst.valid", oVALID, 0);
    check("rst.done", oDONE, 0); check("rst.ready", oREADY, 1);
    checkW("rst", 0, 0, 0, 0);
    $display("reset asserted mid-update, weights cleared");
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    check("postrst.ready", oREADY, 1);
    loadW(0, 256); loadW(1, 256);
    runOp(0, 0, 0, vc, dc, vn);
    check("postrst.output", oOUTPUT, 192); check("postrst.doneCyc", dc, 6);
    checkW("postrst", 256, 256, 0, 0);

    repeat (2) @(posedge iCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
